// File: rtl/reg_wb_queue_if.sv
// Write-back queue bundle: ALU/load write requests, register-block write port, read forwarding.
interface reg_wb_queue_if #(
  parameter int n         = 16,
  parameter int addr_size = 3
);
  logic                 AluValid;
  logic [addr_size-1:0] AluAddr;
  logic [n-1:0]         AluData;
  logic                 AluReady;
  logic                 MemValid;
  logic [addr_size-1:0] MemAddr;
  logic [n-1:0]         MemData;
  logic                 MemReady;
  logic                 We;
  logic [addr_size-1:0] Rw;
  logic [n-1:0]         WData;
  logic [addr_size-1:0] Rs1;
  logic [addr_size-1:0] Rs2;
  logic [n-1:0]         RegRd1;
  logic [n-1:0]         RegRd2;
  logic [n-1:0]         Rd1;
  logic [n-1:0]         Rd2;
  logic [addr_size:0]   Count;
  logic                 Full;
  logic                 Empty;

  modport master (
    output AluValid, AluAddr, AluData, MemValid, MemAddr, MemData,
           Rs1, Rs2, RegRd1, RegRd2,
    input  AluReady, MemReady, We, Rw, WData, Rd1, Rd2, Count, Full, Empty
  );

  modport slave (
    input  AluValid, AluAddr, AluData, MemValid, MemAddr, MemData,
           Rs1, Rs2, RegRd1, RegRd2,
    output AluReady, MemReady, We, Rw, WData, Rd1, Rd2, Count, Full, Empty
  );
endinterface

// File: rtl/reg_wb_queue.sv
// In-order write-back FIFO in front of the register file; head drains every cycle (latency 1 when empty).
// Ready depends only on registered Count: ALU needs one free slot, load path needs two.
module reg_wb_queue #(
  parameter int n         = 16,
  parameter int addr_size = 3,
  parameter int depth     = 4
) (
  input logic         Clock,
  input logic         nReset,
  reg_wb_queue_if.slave bus
);
  localparam int PW = $clog2(depth);
  localparam int CW = addr_size + 1;

  logic [PW-1:0]        r_head;
  logic [PW-1:0]        r_tail;
  logic [CW-1:0]        r_count;
  logic [addr_size-1:0] r_addr [depth];
  logic [n-1:0]         r_data [depth];

  logic          w_full;
  logic          w_empty;
  logic          w_alu_rdy;
  logic          w_mem_rdy;
  logic          w_alu_st;
  logic          w_mem_st;
  logic          w_pop;
  logic [PW-1:0] w_mem_idx;
  logic [n-1:0]  w_rd1;
  logic [n-1:0]  w_rd2;

  assign w_full    = (r_count == CW'(depth));
  assign w_empty   = (r_count == '0);
  assign w_alu_rdy = !w_full;
  assign w_mem_rdy = (r_count <= CW'(depth - 2));
  assign w_pop     = !w_empty;

  // Register 0 writes are acknowledged but never occupy a slot.
  assign w_alu_st  = bus.AluValid && w_alu_rdy && (bus.AluAddr != '0);
  assign w_mem_st  = bus.MemValid && w_mem_rdy && (bus.MemAddr != '0);
  assign w_mem_idx = r_tail + PW'(w_alu_st);

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < depth; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_alu_st) begin
        r_addr[r_tail] <= bus.AluAddr;
        r_data[r_tail] <= bus.AluData;
      end
      if (w_mem_st) begin
        r_addr[w_mem_idx] <= bus.MemAddr;
        r_data[w_mem_idx] <= bus.MemData;
      end
      r_tail  <= r_tail + PW'(w_alu_st) + PW'(w_mem_st);
      r_head  <= r_head + PW'(w_pop);
      r_count <= r_count + CW'(w_alu_st) + CW'(w_mem_st) - CW'(w_pop);
    end
  end

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    w_rd1 = bus.RegRd1;
    w_rd2 = bus.RegRd2;
    for (int i = 0; i < depth; i++) begin
      if (CW'(i) < r_count) begin
        if (r_addr[r_head + PW'(i)] == bus.Rs1) w_rd1 = r_data[r_head + PW'(i)];
        if (r_addr[r_head + PW'(i)] == bus.Rs2) w_rd2 = r_data[r_head + PW'(i)];
      end
    end
    if (bus.Rs1 == '0) w_rd1 = '0;
    if (bus.Rs2 == '0) w_rd2 = '0;
  end

  assign bus.AluReady = w_alu_rdy;
  assign bus.MemReady = w_mem_rdy;
  assign bus.We       = w_pop;
  assign bus.Rw       = r_addr[r_head];
  assign bus.WData    = r_data[r_head];
  assign bus.Rd1      = w_rd1;
  assign bus.Rd2      = w_rd2;
  assign bus.Count    = r_count;
  assign bus.Full     = w_full;
  assign bus.Empty    = w_empty;
endmodule
